// File: rtl/maze_gen.sv
// maze_gen: binary-tree maze carver; in start/num/seed, out map (row-major, 1=passable)/busy/done/map_valid/err
module maze_gen #(
  parameter int NMAX = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           num,
  input  logic [15:0]          seed,
  output logic [NMAX*NMAX-1:0] map,
  output logic                 busy,
  output logic                 done,
  output logic                 map_valid,
  output logic                 err
);
  localparam int IW = $clog2(NMAX*NMAX);
  localparam logic [1:0] IDLE = 2'd0, CARVE = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [NMAX*NMAX-1:0] map_q, map_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d, err_q, err_d;
  logic [4:0] num_q, num_d, x_q, x_d, y_q, y_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [IW-1:0] idx, widx, nidx;
  logic legal, last_x, west, north;
  always_comb begin
    legal = num[0] && num >= 5'd5 && num <= 5'(NMAX);
    idx = IW'(y_q) * IW'(num_q) + IW'(x_q);
    widx = idx - IW'(1);
    nidx = idx - IW'(num_q);
    last_x = x_q == num_q - 5'd1;
    west = x_q != 5'd0 && (y_q == 5'd0 || !lfsr_q[0]);
    north = y_q != 5'd0 && (x_q == 5'd0 || lfsr_q[0]);
    lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0);
    state_d = state_q;
    map_d = map_q;
    busy_d = busy_q;
    done_d = 1'b0;
    valid_d = valid_q;
    err_d = 1'b0;
    num_d = num_q;
    x_d = x_q;
    y_d = y_q;
    lfsr_d = lfsr_q;
    if (state_q == IDLE && start) begin
      if (legal) begin
        state_d = CARVE;
        map_d = '0;
        valid_d = 1'b0;
        busy_d = 1'b1;
        num_d = num;
        lfsr_d = seed == 16'h0 ? 16'hACE1 : seed;
        x_d = 5'd0;
        y_d = 5'd0;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == CARVE) begin
      map_d[idx] = 1'b1;
      if (west) map_d[widx] = 1'b1;
      if (north) map_d[nidx] = 1'b1;
      lfsr_d = lfsr_nx;
      x_d = last_x ? 5'd0 : x_q + 5'd2;
      y_d = last_x ? y_q + 5'd2 : y_q;
      state_d = last_x && y_q == num_q - 5'd1 ? DONE : CARVE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      done_d = 1'b1;
      busy_d = 1'b0;
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      map_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      num_q <= 5'd5;
      x_q <= 5'd0;
      y_q <= 5'd0;
      lfsr_q <= 16'hACE1;
    end else begin
      state_q <= state_d;
      map_q <= map_d;
      busy_q <= busy_d;
      done_q <= done_d;
      valid_q <= valid_d;
      err_q <= err_d;
      num_q <= num_d;
      x_q <= x_d;
      y_q <= y_d;
      lfsr_q <= lfsr_d;
    end
  end
  assign map = map_q;
  assign busy = busy_q;
  assign done = done_q;
  assign map_valid = valid_q;
  assign err = err_q;
endmodule

// File: tb/tb_maze_gen.sv
// tb_maze_gen: randomized self-checking bench for maze_gen against a room-walk reference model
module tb_maze_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0] num = 5'd5;
  logic [15:0] seed = 16'h0;
  logic [360:0] map;
  logic busy, done, map_valid, err;
  int checks = 0, errors = 0;
  maze_gen #(.NMAX(19)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .seed(seed),
    .map(map), .busy(busy), .done(done), .map_valid(map_valid), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [360:0] model(input int n, input logic [15:0] s);
    logic [360:0] m = '0;
    logic [15:0] l = (s == 16'h0) ? 16'hACE1 : s;
    for (int y = 0; y < n; y += 2)
      for (int x = 0; x < n; x += 2) begin
        int c = y * n + x;
        bit coin = l[0];
        m[c] = 1'b1;
        if (x > 0 && y > 0) m[coin ? c - n : c - 1] = 1'b1;
        else if (x > 0) m[c - 1] = 1'b1;
        else if (y > 0) m[c - n] = 1'b1;
        l = coin ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
    return m;
  endfunction
  function automatic bit reach(input logic [360:0] m, input int n);
    bit seen[361];
    int q[$];
    if (!m[0]) return 1'b0;
    q.push_back(0);
    seen[0] = 1'b1;
    while (q.size() > 0) begin
      int c = q.pop_front();
      int x = c % n;
      int y = c / n;
      if (c == n * n - 1) return 1'b1;
      for (int d = 0; d < 4; d++) begin
        int nx = x + int'(d == 0) - int'(d == 1);
        int ny = y + int'(d == 2) - int'(d == 3);
        int nc = ny * n + nx;
        if (nx >= 0 && nx < n && ny >= 0 && ny < n && m[nc] && !seen[nc]) begin
          seen[nc] = 1'b1;
          q.push_back(nc);
        end
      end
    end
    return 1'b0;
  endfunction
  task automatic run(input int n, input logic [15:0] s, output logic [360:0] got);
    int r = ((n + 1) / 2) * ((n + 1) / 2);
    int lat = -1, bc = 0;
    logic [360:0] exp_m = model(n, s);
    @(negedge clk);
    start = 1'b1; num = 5'(n); seed = s;
    @(posedge clk); #1;
    start = 1'b0; num = 5'($urandom); seed = 16'($urandom);
    if (busy) bc++;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) lat = k;
    end
    checks++; if (lat != r + 1) begin errors++; $display("FAIL done_latency n=%0d got %0d exp %0d", n, lat, r + 1); end
    checks++; if (bc != r + 1) begin errors++; $display("FAIL busy_cycles n=%0d got %0d exp %0d", n, bc, r + 1); end
    checks++; if (map !== exp_m) begin errors++; $display("FAIL map n=%0d seed=%h got %h exp %h", n, s, map, exp_m); end
    checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL map_valid n=%0d got %b exp 1", n, map_valid); end
    checks++; if ($countones(map) != 2 * r - 1) begin errors++; $display("FAIL popcount n=%0d got %0d exp %0d", n, $countones(map), 2 * r - 1); end
    got = map;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse n=%0d got %b exp 0", n, done); end
    checks++; if (map !== got) begin errors++; $display("FAIL map_hold n=%0d got %h exp %h", n, map, got); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (map !== '0) begin errors++; $display("FAIL reset_map got %h exp 0", map); end
    checks++; if ({busy, done, map_valid, err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, map_valid, err}); end
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_small;
    logic [360:0] g;
    int rooms[9] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};
    int oo[4] = '{6, 8, 16, 18};
    run(5, 16'h0001, g);
    foreach (rooms[i]) begin
      checks++; if (g[rooms[i]] !== 1'b1) begin errors++; $display("FAIL room_bit %0d got %b exp 1", rooms[i], g[rooms[i]]); end
    end
    foreach (oo[i]) begin
      checks++; if (g[oo[i]] !== 1'b0) begin errors++; $display("FAIL oddodd_bit %0d got %b exp 0", oo[i], g[oo[i]]); end
    end
    checks++; if ((g >> 25) !== '0) begin errors++; $display("FAIL bits_above_25 got %h exp 0", g >> 25); end
  endtask
  task automatic test_large;
    logic [360:0] g;
    run(19, 16'h1234, g);
    checks++; if (!reach(g, 19)) begin errors++; $display("FAIL bfs_reach got 0 exp 1"); end
  endtask
  task automatic test_seed_zero;
    logic [360:0] a, b;
    run(7, 16'h0000, a);
    run(7, 16'hACE1, b);
    checks++; if (a !== b) begin errors++; $display("FAIL seed_zero got %h exp %h", a, b); end
  endtask
  task automatic test_err;
    int bad[2] = '{4, 21};
    foreach (bad[i]) begin
      logic [360:0] pm = map;
      logic pv = map_valid;
      @(negedge clk);
      start = 1'b1; num = 5'(bad[i]); seed = 16'h3;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse num=%0d got %b exp 1", bad[i], err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy num=%0d got %b exp 0", bad[i], busy); end
      @(posedge clk); #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width num=%0d got %b exp 0", bad[i], err); end
      checks++; if (map !== pm || map_valid !== pv || busy !== 1'b0) begin errors++; $display("FAIL err_nochange num=%0d got %h/%b exp %h/%b", bad[i], map, map_valid, pm, pv); end
    end
  endtask
  task automatic test_midrun_ignore;
    logic [360:0] exp_m = model(9, 16'h5A5A);
    int lat = -1;
    @(negedge clk);
    start = 1'b1; num = 5'd9; seed = 16'h5A5A;
    @(posedge clk); #1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      start = (k == 3); num = 5'(2 * $urandom_range(2, 9) + 1); seed = 16'($urandom);
      @(posedge clk); #1;
      if (done) lat = k;
    end
    start = 1'b0;
    checks++; if (lat != 26) begin errors++; $display("FAIL midrun_latency got %0d exp 26", lat); end
    checks++; if (map !== exp_m) begin errors++; $display("FAIL midrun_map got %h exp %h", map, exp_m); end
  endtask
  task automatic test_reset_midrun;
    logic [360:0] g;
    bit saw = 1'b0;
    @(negedge clk);
    start = 1'b1; num = 5'd9; seed = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rst = (k == 5); start = (k == 5); num = 5'd9;
      @(posedge clk); #1;
    end
    checks++; if (map !== '0) begin errors++; $display("FAIL rst_mid_map got %h exp 0", map); end
    checks++; if ({busy, done, map_valid, err} !== 4'b0) begin errors++; $display("FAIL rst_mid_flags got %b exp 0000", {busy, done, map_valid, err}); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    checks++; if (saw) begin errors++; $display("FAIL rst_mid_quiet got activity exp none"); end
    run(9, 16'h7777, g);
  endtask
  task automatic test_back_to_back;
    logic [360:0] g;
    for (int i = 0; i < 6; i++) run(2 * $urandom_range(2, 9) + 1, 16'($urandom), g);
  endtask
  initial begin
    test_reset();
    test_small();
    test_large();
    test_seed_zero();
    test_err();
    test_midrun_ignore();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
